// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, tag carried alongside.
// Latency 3 edges: out_valid rises after the third edge, counting the capture edge.
// Backpressure: valid/ready per stage, full throughput; define WALLACE_SIGNED_EN for two's complement.
module wallace_mult_pipe #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic [TAG_W-1:0]   out_tag
);

   localparam int PW   = 2 * WIDTH;
   // Number of 3:2 levels that always brings up to 32 rows down to 2
   // (32-22-15-10-7-5-4-3-2); extra levels are plain pass-through wiring.
   localparam int MAXL = 9;

   // Row count entering reduction level lvl.
   function automatic int rows_at(input int lvl);
      int n;
      n = WIDTH;
      for (int i = 0; i < lvl; i++) begin
         if (n > 2) n = (n / 3) * 2 + (n % 3);
      end
      return n;
   endfunction

   logic             adv1, adv2, adv3;
   logic             v1, v2, v3;
   logic [WIDTH-1:0] a1, b1;
   logic [TAG_W-1:0] tag1, tag2, tag3;
   logic [PW-1:0]    sum2, carry2, p3;
   logic [PW-1:0]    red_sum, red_carry;
   logic [PW-1:0]    pp [WIDTH];

   // A stage may load when it is empty or its successor is moving this cycle.
   always_comb begin
      adv3     = !v3 | out_ready;
      adv2     = !v2 | adv3;
      adv1     = !v1 | adv2;
      in_ready = adv1;
      out_valid = v3;
      out_p     = p3;
      out_tag   = tag3;
   end

   // Partial-product rows. The signed build uses Baugh-Wooley: terms pairing
   // exactly one operand MSB are complemented, and the two constant 1s are
   // folded into bit positions of rows 0 and WIDTH-1 that are otherwise empty.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pp
      wire [WIDTH-1:0] r;
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
`ifdef WALLACE_SIGNED_EN
         if ((i == WIDTH - 1) != (j == WIDTH - 1)) begin : g_inv
            assign r[j] = ~(a1[j] & b1[i]);
         end else begin : g_pos
            assign r[j] = a1[j] & b1[i];
         end
`else
         assign r[j] = a1[j] & b1[i];
`endif
      end
`ifdef WALLACE_SIGNED_EN
      localparam logic [PW-1:0] CST =
         ((i == 0)         ? (PW'(1) << WIDTH)    : PW'(0)) |
         ((i == WIDTH - 1) ? (PW'(1) << (PW - 1)) : PW'(0));
`else
      localparam logic [PW-1:0] CST = '0;
`endif
      assign pp[i] = (PW'(r) << i) | CST;
   end

   // Wallace reduction: each level groups rows in threes and replaces every
   // group with a sum row and a carry row (column-wise full adders; columns
   // where only two bits are live collapse to half adders once the constant
   // zeros propagate). Leftover rows pass straight to the next level.
   for (genvar l = 0; l < MAXL; l++) begin : g_lvl
      localparam int NIN  = rows_at(l);
      localparam int NGRP = (NIN > 2) ? NIN / 3 : 0;
      localparam int NOUT = rows_at(l + 1);
      logic [PW-1:0] cur [NIN];
      logic [PW-1:0] nxt [NOUT];

      for (genvar r = 0; r < NIN; r++) begin : g_src
         if (l == 0) begin : g_from_pp
            assign cur[r] = pp[r];
         end else begin : g_from_prev
            assign cur[r] = g_lvl[l-1].nxt[r];
         end
      end

      for (genvar g = 0; g < NGRP; g++) begin : g_csa
         wire [PW-1:0] x = cur[3*g];
         wire [PW-1:0] y = cur[3*g+1];
         wire [PW-1:0] z = cur[3*g+2];
         assign nxt[2*g]   = x ^ y ^ z;
         // Carry out of the top column falls outside 2*WIDTH bits and is dropped.
         assign nxt[2*g+1] = {(x[PW-2:0] & y[PW-2:0]) | (x[PW-2:0] & z[PW-2:0]) |
                              (y[PW-2:0] & z[PW-2:0]), 1'b0};
      end

      for (genvar r = 3 * NGRP; r < NIN; r++) begin : g_pass
         assign nxt[r - NGRP] = cur[r];
      end
   end

   assign red_sum   = g_lvl[MAXL-1].nxt[0];
   assign red_carry = g_lvl[MAXL-1].nxt[1];

   // S1: operand and tag registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         tag1 <= '0;
      end else if (adv1) begin
         v1   <= in_valid;
         a1   <= in_a;
         b1   <= in_b;
         tag1 <= in_tag;
      end
   end

   // S2: register the two rows left by the reduction tree.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         v2     <= 1'b0;
         sum2   <= '0;
         carry2 <= '0;
         tag2   <= '0;
      end else if (adv2) begin
         v2     <= v1;
         sum2   <= red_sum;
         carry2 <= red_carry;
         tag2   <= tag1;
      end
   end

   // S3: carry-propagate add, result held while the consumer stalls.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         v3   <= 1'b0;
         p3   <= '0;
         tag3 <= '0;
      end else if (adv3) begin
         v3   <= v2;
         p3   <= sum2 + carry2;
         tag3 <= tag2;
      end
   end

endmodule
